alut_mem_arb: RTL and testbench

ALUT_MEM_ARB -- requirements
Module: alut_mem_arb

---
 rtl/alut_mem_arb.sv | 137 +++++++++++++
 tb/tb_alut_mem_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alut_mem_arb.sv
// Arbitrates the add and age requesters onto one ALUT RAM port, with lock for read-modify-write.
// Latency: grant is combinational, the RAM access is registered one cycle later, read data returns two cycles after grant.
// Backpressure: a requester holds its request until granted; age gets priority after MAX_WAIT denied cycles.
module alut_mem_arb #(
  parameter int DW       = 83,
  parameter int AW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          pclk,
  input  logic          p_reset,
  input  logic          add_req,
  input  logic          add_lock,
  input  logic          add_we,
  input  logic [AW-1:0] add_addr,
  input  logic [DW-1:0] add_wdata,
  output logic          add_gnt,
  output logic          add_rvalid,
  output logic [DW-1:0] add_rdata,
  input  logic          age_req,
  input  logic          age_lock,
  input  logic          age_we,
  input  logic [AW-1:0] age_addr,
  input  logic [DW-1:0] age_wdata,
  output logic          age_gnt,
  output logic          age_rvalid,
  output logic [DW-1:0] age_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          age_boost
);

  typedef enum logic [1:0] {IDLE, LOCK_ADD, LOCK_AGE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    wait_cnt;
  acc_t          acc_sel;
  logic          any_gnt;
  logic          rd_add_q;
  logic          rd_age_q;
  logic [DW-1:0] add_rdata_q;
  logic [DW-1:0] age_rdata_q;

  assign age_boost = (wait_cnt == WAIT_MAX);
  assign any_gnt   = add_gnt | age_gnt;

  // A lock reserves exactly one following cycle; the locked requester may leave it unused.
  always_comb begin
    add_gnt   = 1'b0;
    age_gnt   = 1'b0;
    state_nxt = IDLE;
    if (!p_reset) begin
      case (state)
        IDLE: begin
          if (age_req && (age_boost || !add_req)) begin
            age_gnt = 1'b1;
            if (age_lock) state_nxt = LOCK_AGE;
          end else if (add_req) begin
            add_gnt = 1'b1;
            if (add_lock) state_nxt = LOCK_ADD;
          end
        end
        LOCK_ADD: add_gnt = add_req;
        LOCK_AGE: age_gnt = age_req;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      wait_cnt <= 3'd0;
    end else if (age_req && !age_gnt) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 3'd1;
    end else begin
      wait_cnt <= 3'd0;
    end
  end

  assign acc_sel = age_gnt ? acc_t'{age_we, age_addr, age_wdata}
                           : acc_t'{add_we, add_addr, add_wdata};

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= any_gnt;
      mem_we <= any_gnt & acc_sel.we;
      if (any_gnt) begin
        mem_addr  <= acc_sel.addr;
        mem_wdata <= acc_sel.wdata;
      end
    end
  end

  // Read ownership follows the access through the RAM's one-cycle read latency.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      rd_add_q    <= 1'b0;
      rd_age_q    <= 1'b0;
      add_rvalid  <= 1'b0;
      age_rvalid  <= 1'b0;
      add_rdata_q <= '0;
      age_rdata_q <= '0;
    end else begin
      rd_add_q   <= add_gnt & ~add_we;
      rd_age_q   <= age_gnt & ~age_we;
      add_rvalid <= rd_add_q;
      age_rvalid <= rd_age_q;
      if (add_rvalid) add_rdata_q <= mem_rdata;
      if (age_rvalid) age_rdata_q <= mem_rdata;
    end
  end

  assign add_rdata = add_rvalid ? mem_rdata : add_rdata_q;
  assign age_rdata = age_rvalid ? mem_rdata : age_rdata_q;

endmodule

// File: tb/tb_alut_mem_arb.sv
// Directed bench for alut_mem_arb with a behavioural RAM and a read-data scoreboard.
module tb_alut_mem_arb;
  localparam int DW = 83;
  localparam int AW = 8;

  logic          pclk = 1'b0;
  logic          p_reset;
  logic          add_req, add_lock, add_we;
  logic [AW-1:0] add_addr;
  logic [DW-1:0] add_wdata;
  logic          add_gnt, add_rvalid;
  logic [DW-1:0] add_rdata;
  logic          age_req, age_lock, age_we;
  logic [AW-1:0] age_addr;
  logic [DW-1:0] age_wdata;
  logic          age_gnt, age_rvalid;
  logic [DW-1:0] age_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          age_boost;

  alut_mem_arb #(.DW(DW), .AW(AW), .MAX_WAIT(4)) dut (
    .pclk(pclk), .p_reset(p_reset),
    .add_req(add_req), .add_lock(add_lock), .add_we(add_we), .add_addr(add_addr),
    .add_wdata(add_wdata), .add_gnt(add_gnt), .add_rvalid(add_rvalid), .add_rdata(add_rdata),
    .age_req(age_req), .age_lock(age_lock), .age_we(age_we), .age_addr(age_addr),
    .age_wdata(age_wdata), .age_gnt(age_gnt), .age_rvalid(age_rvalid), .age_rdata(age_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .age_boost(age_boost)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] dat;
    int            due;
  } exp_t;

  exp_t exp_add_q[$];
  exp_t exp_age_q[$];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    v[DW-1 -: 8] = a;
    v[31:0] = {a, a, a, a} ^ 32'h5A5A_1234;
    return v;
  endfunction

  // Behavioural RAM: one-cycle registered read, unwritten entries return pat(addr).
  logic [DW-1:0] ram [256];
  logic          ram_v [256];
  always @(posedge pclk) begin
    if (p_reset) begin
      for (int i = 0; i < 256; i++) ram_v[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        ram_v[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : pat(mem_addr);
      end
    end
  end

  // Bench-side shadow of what the RAM should hold, updated from granted writes.
  logic [DW-1:0] sh [256];
  logic          shv [256];
  function automatic logic [DW-1:0] mem_exp(input logic [AW-1:0] a);
    return shv[a] ? sh[a] : pat(a);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    exp_t e;
    if (p_reset) begin
      exp_add_q.delete();
      exp_age_q.delete();
      for (int i = 0; i < 256; i++) shv[i] = 1'b0;
    end else begin
      if (add_rvalid) begin
        if (exp_add_q.size() == 0) chk("add_spurious_rvalid", DW'(add_rvalid), '0);
        else begin
          e = exp_add_q.pop_front();
          chk("add_rdata", add_rdata, e.dat);
          chk("add_rvalid_cycle", DW'(cyc), DW'(e.due));
        end
      end
      if (age_rvalid) begin
        if (exp_age_q.size() == 0) chk("age_spurious_rvalid", DW'(age_rvalid), '0);
        else begin
          e = exp_age_q.pop_front();
          chk("age_rdata", age_rdata, e.dat);
          chk("age_rvalid_cycle", DW'(cyc), DW'(e.due));
        end
      end
      if (add_gnt) begin
        if (add_we) begin
          sh[add_addr] = add_wdata;
          shv[add_addr] = 1'b1;
        end else exp_add_q.push_back('{mem_exp(add_addr), cyc + 2});
      end
      if (age_gnt) begin
        if (age_we) begin
          sh[age_addr] = age_wdata;
          shv[age_addr] = 1'b1;
        end else exp_age_q.push_back('{mem_exp(age_addr), cyc + 2});
      end
    end
  end

  task automatic next_cycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic mid();
    @(negedge pclk);
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] wval;
    ones = '1;
    p_reset = 1'b1;
    add_req = 1'b1; add_lock = 1'b0; add_we = 1'b0; add_addr = '0; add_wdata = '0;
    age_req = 1'b1; age_lock = 1'b0; age_we = 1'b0; age_addr = '0; age_wdata = '0;

    // Reset state, with both requests asserted to confirm grants are held off
    next_cycle();
    next_cycle();
    mid();
    chk("rst_add_gnt", DW'(add_gnt), '0);
    chk("rst_age_gnt", DW'(age_gnt), '0);
    chk("rst_mem_en", DW'(mem_en), '0);
    chk("rst_mem_we", DW'(mem_we), '0);
    chk("rst_mem_addr", DW'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_age_boost", DW'(age_boost), '0);
    chk("rst_add_rvalid", DW'(add_rvalid), '0);
    chk("rst_add_rdata", add_rdata, '0);
    chk("rst_age_rdata", age_rdata, '0);
    next_cycle();
    p_reset = 1'b0; add_req = 1'b0; age_req = 1'b0;
    next_cycle();

    // Single read of 8'h12
    add_req = 1'b1; add_we = 1'b0; add_addr = 8'h12;
    mid();
    chk("rd_add_gnt", DW'(add_gnt), DW'(1));
    chk("rd_age_gnt", DW'(age_gnt), '0);
    next_cycle();
    add_req = 1'b0;
    mid();
    chk("rd_mem_en", DW'(mem_en), DW'(1));
    chk("rd_mem_we", DW'(mem_we), '0);
    chk("rd_mem_addr", DW'(mem_addr), DW'(8'h12));
    next_cycle();
    mid();
    chk("rd_add_rvalid", DW'(add_rvalid), DW'(1));
    chk("rd_age_rvalid", DW'(age_rvalid), '0);
    next_cycle();
    mid();
    chk("rd_idle_mem_en", DW'(mem_en), '0);
    chk("rd_rvalid_drop", DW'(add_rvalid), '0);
    chk("rd_rdata_hold", add_rdata, mem_exp(8'h12));

    // Contention: add wins four cycles, then boosted age wins one
    next_cycle();
    add_req = 1'b1; add_addr = 8'h20;
    age_req = 1'b1; age_we = 1'b0; age_addr = 8'h30;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk($sformatf("cont_add_gnt_%0d", k), DW'(add_gnt), DW'(k % 5 != 4));
      chk($sformatf("cont_age_gnt_%0d", k), DW'(age_gnt), DW'(k % 5 == 4));
      chk($sformatf("cont_boost_%0d", k), DW'(age_boost), DW'(k % 5 == 4));
      if (k > 0) chk($sformatf("cont_mem_en_%0d", k), DW'(mem_en), DW'(1));
      next_cycle();
    end
    add_req = 1'b0; age_req = 1'b0;
    repeat (3) next_cycle();

    // Lock: add read-modify-write of 8'h05 holds age off for one cycle
    add_req = 1'b1; add_lock = 1'b1; add_we = 1'b0; add_addr = 8'h05;
    age_req = 1'b1; age_addr = 8'h40;
    mid();
    chk("lk_add_gnt0", DW'(add_gnt), DW'(1));
    next_cycle();
    wval = pat(8'h77) ^ {DW{1'b1}};
    add_lock = 1'b0; add_we = 1'b1; add_wdata = wval;
    mid();
    chk("lk_add_gnt1", DW'(add_gnt), DW'(1));
    chk("lk_age_gnt1", DW'(age_gnt), '0);
    next_cycle();
    add_req = 1'b0; add_we = 1'b0;
    mid();
    chk("lk_age_gnt2", DW'(age_gnt), DW'(1));
    chk("lk_mem_we", DW'(mem_we), DW'(1));
    chk("lk_mem_wdata", mem_wdata, wval);
    next_cycle();
    age_req = 1'b0;

    // Age lock left unused: add denied for that cycle, granted the next
    age_req = 1'b1; age_lock = 1'b1; age_we = 1'b1; age_addr = 8'h50; age_wdata = pat(8'h99);
    mid();
    chk("ul_age_gnt", DW'(age_gnt), DW'(1));
    next_cycle();
    age_req = 1'b0; age_lock = 1'b0; age_we = 1'b0;
    add_req = 1'b1; add_we = 1'b0; add_addr = 8'h50;
    mid();
    chk("ul_add_denied", DW'(add_gnt), '0);
    chk("ul_age_none", DW'(age_gnt), '0);
    next_cycle();
    mid();
    chk("ul_add_gnt", DW'(add_gnt), DW'(1));
    next_cycle();
    add_req = 1'b0;
    repeat (3) next_cycle();

    // All-ones write then read at 8'hFF
    add_req = 1'b1; add_we = 1'b1; add_addr = 8'hFF; add_wdata = ones;
    next_cycle();
    add_we = 1'b0;
    next_cycle();
    add_req = 1'b0;
    mid();
    chk("ff_write_no_rvalid", DW'(add_rvalid), '0);
    next_cycle();
    mid();
    chk("ff_read_rvalid", DW'(add_rvalid), DW'(1));
    chk("ff_read_ones", add_rdata, ones);
    next_cycle();

    // Reset one cycle after a read grant cancels the return
    age_req = 1'b1; age_we = 1'b0; age_addr = 8'h60;
    mid();
    chk("rr_age_gnt", DW'(age_gnt), DW'(1));
    next_cycle();
    p_reset = 1'b1; age_req = 1'b0;
    mid();
    chk("rr_mem_en", DW'(mem_en), '0);
    next_cycle();
    mid();
    chk("rr_age_rvalid", DW'(age_rvalid), '0);
    chk("rr_age_rdata", age_rdata, '0);
    chk("rr_add_rdata", add_rdata, '0);
    chk("rr_mem_addr", DW'(mem_addr), '0);
    chk("rr_mem_wdata", mem_wdata, '0);
    next_cycle();
    p_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk($sformatf("rr_post_age_rvalid_%0d", k), DW'(age_rvalid), '0);
      next_cycle();
    end

    chk("end_add_q_empty", DW'(exp_add_q.size()), '0);
    chk("end_age_q_empty", DW'(exp_age_q.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
